// File: rtl/panel_seq.sv
// panel_seq: front-panel sequencer; arbitrates panel buttons against core execution and owns the panel memory port.
// Latency: a press acts on the next edge; load display +2 cycles, look display +3 cycles, plus one per mem_rdy_i stall.
// Backpressure: mem_val_o is held with stable addr/data until mem_rdy_i; presses are ignored while a request is in flight.
module panel_seq #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int NBRK   = 4,
  parameter int STEP_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   btn_load_i,
  input  logic                   btn_look_i,
  input  logic                   btn_step_i,
  input  logic                   btn_run_i,
  input  logic                   btn_enter_i,
  input  logic                   btn_stop_i,
  output logic                   btn_load_o,
  output logic                   btn_look_o,
  output logic                   btn_step_o,
  output logic                   btn_run_o,
  output logic                   btn_enter_o,
  output logic                   btn_stop_o,
  output logic                   led_ready_o,
  output logic                   led_inwait_o,
  output logic                   led_halt_o,
  output logic                   led_brk_o,
  input  logic [ADDR_W-1:0]      sw_addr_i,
  input  logic [DATA_W-1:0]      sw_data_i,
  input  logic [STEP_W-1:0]      sw_step_i,
  input  logic                   auto_inc_i,
  input  logic [NBRK-1:0]        brk_en_i,
  input  logic [NBRK*ADDR_W-1:0] brk_addr_i,
  output logic                   core_run_o,
  input  logic                   core_retire_i,
  input  logic [ADDR_W-1:0]      core_pc_i,
  input  logic                   core_halt_i,
  input  logic                   core_inwait_i,
  input  logic                   core_idle_i,
  output logic                   pc_wen_o,
  output logic [ADDR_W-1:0]      pc_o,
  output logic                   mem_val_o,
  output logic                   mem_wen_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic                   mem_rdy_i,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  output logic [ADDR_W-1:0]      disp_addr_o,
  output logic [DATA_W-1:0]      disp_data_o
);

  typedef enum logic [2:0] {
    S_READY, S_RUN, S_STEP, S_DRAIN, S_FETCH, S_INWAIT, S_HALT
  } state_t;

  state_t              state_q, state_d, tgt_q, tgt_d;
  logic [STEP_W-1:0]   stepcnt_q;
  logic [ADDR_W-1:0]   cur_addr_q, acc_target;
  logic                auto_q, cap_q;
  logic                busy, accept, acc_done, run_start;
  logic                start_acc, acc_load, stop_hit, brk_stop, brk_hit;

  assign busy       = mem_val_o | cap_q;
  assign accept     = mem_val_o & mem_rdy_i;
  // a load finishes on acceptance, a look once its read data has been captured
  assign acc_done   = (accept & mem_wen_o) | (cap_q & (state_q != S_FETCH));
  assign acc_target = (auto_inc_i && auto_q) ? cur_addr_q + ADDR_W'(1) : sw_addr_i;
  assign pc_wen_o   = accept & (state_q != S_FETCH);
  assign pc_o       = mem_addr_o;
  assign run_start  = (state_q == S_READY) && ((state_d == S_RUN) || (state_d == S_STEP));

  // any enabled comparator matching the next PC
  always_comb begin
    brk_hit = 1'b0;
    for (int k = 0; k < NBRK; k++)
      if (brk_en_i[k] && (brk_addr_i[k*ADDR_W +: ADDR_W] == core_pc_i)) brk_hit = 1'b1;
  end

  // state register and latched post-fetch target
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_READY;
      tgt_q   <= S_READY;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // next state, lamps, button enables and core run gating
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    core_run_o   = 1'b0;
    btn_load_o   = 1'b0;
    btn_look_o   = 1'b0;
    btn_step_o   = 1'b0;
    btn_run_o    = 1'b0;
    btn_enter_o  = 1'b0;
    btn_stop_o   = 1'b0;
    led_ready_o  = 1'b0;
    led_inwait_o = 1'b0;
    led_halt_o   = 1'b0;
    start_acc    = 1'b0;
    acc_load     = 1'b0;
    stop_hit     = 1'b0;
    brk_stop     = 1'b0;
    case (state_q)
      S_READY: begin
        {btn_load_o, btn_look_o, btn_step_o, btn_run_o, btn_enter_o} = 5'b11111;
        led_ready_o = 1'b1;
        if (!busy) begin
          if (btn_run_i)       state_d = S_RUN;
          else if (btn_step_i) state_d = S_STEP;
          else if (btn_load_i) begin start_acc = 1'b1; acc_load = 1'b1; end
          else if (btn_look_i) start_acc = 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        btn_stop_o = (state_q == S_RUN);
        core_run_o = (state_q == S_RUN) || (stepcnt_q != '0);
        // stop conditions in priority order; only inwait and the stop button act without a retire
        if (core_retire_i && core_halt_i) begin
          stop_hit = 1'b1; tgt_d = S_HALT;
        end else if (core_inwait_i) begin
          stop_hit = 1'b1; tgt_d = S_INWAIT;
        end else if (core_retire_i && brk_hit) begin
          stop_hit = 1'b1; brk_stop = 1'b1; tgt_d = S_READY;
        end else if ((state_q == S_STEP) && core_retire_i && (stepcnt_q <= STEP_W'(1))) begin
          stop_hit = 1'b1; tgt_d = S_READY;
        end else if ((state_q == S_RUN) && btn_stop_i) begin
          stop_hit = 1'b1; tgt_d = S_READY;
        end
        if (stop_hit) begin
          core_run_o = 1'b0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: if (core_idle_i) state_d = S_FETCH;
      S_FETCH: if (cap_q) state_d = tgt_q;
      S_INWAIT: begin
        {btn_load_o, btn_look_o, btn_enter_o} = 3'b111;
        led_inwait_o = 1'b1;
        if (!busy) begin
          if (btn_enter_i)     state_d = S_READY;
          else if (btn_load_i) begin start_acc = 1'b1; acc_load = 1'b1; end
          else if (btn_look_i) start_acc = 1'b1;
        end
      end
      S_HALT: begin
        {btn_load_o, btn_look_o} = 2'b11;
        led_halt_o = 1'b1;
        if (!busy) begin
          if (btn_load_i)      begin start_acc = 1'b1; acc_load = 1'b1; end
          else if (btn_look_i) start_acc = 1'b1;
        end
        if (acc_done) state_d = S_READY;
      end
      default: state_d = S_READY;
    endcase
  end

  // memory port, display registers, auto-increment and step/breakpoint bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_val_o   <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cap_q       <= 1'b0;
      cur_addr_q  <= '0;
      auto_q      <= 1'b0;
      stepcnt_q   <= '0;
      led_brk_o   <= 1'b0;
      disp_addr_o <= '0;
      disp_data_o <= '0;
    end else begin
      cap_q <= accept & ~mem_wen_o;
      if (start_acc) begin
        mem_val_o   <= 1'b1;
        mem_wen_o   <= acc_load;
        mem_addr_o  <= acc_target;
        mem_wdata_o <= sw_data_i;
      end else if ((state_q == S_DRAIN) && (state_d == S_FETCH)) begin
        mem_val_o  <= 1'b1;
        mem_wen_o  <= 1'b0;
        mem_addr_o <= core_pc_i;
      end else if (accept) begin
        mem_val_o <= 1'b0;
      end
      if (accept) begin
        disp_addr_o <= mem_addr_o;
        if (mem_wen_o) disp_data_o <= mem_wdata_o;
        if (state_q != S_FETCH) begin
          cur_addr_q <= mem_addr_o;
          auto_q     <= 1'b1;
        end
      end
      if (cap_q) disp_data_o <= mem_rdata_i;
      if (run_start) begin
        auto_q    <= 1'b0;
        led_brk_o <= 1'b0;
        if (state_d == S_STEP) stepcnt_q <= (sw_step_i == '0) ? STEP_W'(1) : sw_step_i;
      end else if ((state_q == S_STEP) && core_retire_i && (stepcnt_q != '0)) begin
        stepcnt_q <= stepcnt_q - STEP_W'(1);
      end
      if (brk_stop) led_brk_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_panel_seq.sv
module tb_panel_seq;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NB = 4;
  localparam int SW = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic btn_load_i, btn_look_i, btn_step_i, btn_run_i, btn_enter_i, btn_stop_i;
  logic btn_load_o, btn_look_o, btn_step_o, btn_run_o, btn_enter_o, btn_stop_o;
  logic led_ready_o, led_inwait_o, led_halt_o, led_brk_o;
  logic [AW-1:0] sw_addr_i;
  logic [DW-1:0] sw_data_i;
  logic [SW-1:0] sw_step_i;
  logic auto_inc_i;
  logic [NB-1:0] brk_en_i;
  logic [NB*AW-1:0] brk_addr_i;
  logic core_run_o, core_retire_i, core_halt_i, core_inwait_i, core_idle_i;
  logic [AW-1:0] core_pc_i;
  logic pc_wen_o;
  logic [AW-1:0] pc_o;
  logic mem_val_o, mem_wen_o, mem_rdy_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] disp_addr_o;
  logic [DW-1:0] disp_data_o;

  panel_seq #(.ADDR_W(AW), .DATA_W(DW), .NBRK(NB), .STEP_W(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .btn_load_i(btn_load_i), .btn_look_i(btn_look_i), .btn_step_i(btn_step_i),
    .btn_run_i(btn_run_i), .btn_enter_i(btn_enter_i), .btn_stop_i(btn_stop_i),
    .btn_load_o(btn_load_o), .btn_look_o(btn_look_o), .btn_step_o(btn_step_o),
    .btn_run_o(btn_run_o), .btn_enter_o(btn_enter_o), .btn_stop_o(btn_stop_o),
    .led_ready_o(led_ready_o), .led_inwait_o(led_inwait_o), .led_halt_o(led_halt_o),
    .led_brk_o(led_brk_o), .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
    .sw_step_i(sw_step_i), .auto_inc_i(auto_inc_i), .brk_en_i(brk_en_i),
    .brk_addr_i(brk_addr_i), .core_run_o(core_run_o), .core_retire_i(core_retire_i),
    .core_pc_i(core_pc_i), .core_halt_i(core_halt_i), .core_inwait_i(core_inwait_i),
    .core_idle_i(core_idle_i), .pc_wen_o(pc_wen_o), .pc_o(pc_o),
    .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdy_i(mem_rdy_i), .mem_rdata_i(mem_rdata_i),
    .disp_addr_o(disp_addr_o), .disp_data_o(disp_data_o)
  );

  int total = 0;
  int bad = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {~b, b ^ 8'h3C};
  endfunction

  // memory environment
  logic [DW-1:0] mem [256];
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_val_o && mem_rdy_i) begin
      if (mem_wen_o) mem[mem_addr_o] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o];
    end
  end

  // core environment: one instruction per PC, random latency, halt/inwait at chosen addresses
  logic [AW-1:0] pc_core;
  logic exec;
  int cnt;
  int lat_fixed = 0;
  logic [AW-1:0] halt_addr = 8'hF0;
  logic [AW-1:0] inwait_addr = 8'h42;
  logic inwait_arm = 1'b0;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exec <= 1'b0; cnt <= 0; pc_core <= '0;
    end else if (pc_wen_o) begin
      pc_core <= pc_o;
    end else if (exec) begin
      if (cnt == 0) begin exec <= 1'b0; pc_core <= pc_core + 8'd1; end
      else cnt <= cnt - 1;
    end else if (core_run_o && !(inwait_arm && pc_core == inwait_addr)) begin
      exec <= 1'b1;
      cnt  <= (lat_fixed > 0) ? lat_fixed : int'($urandom_range(2, 0));
    end
  end
  assign core_retire_i = exec && (cnt == 0);
  assign core_pc_i     = exec ? pc_core + 8'd1 : pc_core;
  assign core_halt_i   = core_retire_i && (pc_core == halt_addr);
  assign core_inwait_i = !exec && inwait_arm && (pc_core == inwait_addr);
  assign core_idle_i   = !exec;

  // retire monitor
  int ret_cnt = 0;
  logic run_at_ret = 1'b0;
  always @(negedge clk_i) if (core_retire_i === 1'b1) begin
    ret_cnt    <= ret_cnt + 1;
    run_at_ret <= core_run_o;
  end

  // reference model state
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] exp_cur;
  logic exp_auto;
  logic [AW-1:0] exp_pc;

  function automatic logic [AW-1:0] tgt();
    return (auto_inc_i && exp_auto) ? exp_cur + 8'd1 : sw_addr_i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mask bits: 0 load, 1 look, 2 step, 3 run, 4 enter, 5 stop
  task automatic press(input logic [5:0] m);
    {btn_stop_i, btn_enter_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i} = m;
    @(negedge clk_i);
    {btn_stop_i, btn_enter_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i} = '0;
  endtask

  function automatic logic lamp(input int sel);
    case (sel)
      0: return led_ready_o;
      1: return led_halt_o;
      default: return led_inwait_o;
    endcase
  endfunction

  task automatic wait_lamp(input int sel, input string tag);
    int n;
    n = 0;
    while (lamp(sel) !== 1'b1 && n < 400) begin @(negedge clk_i); n++; end
    chk(tag, {31'd0, lamp(sel)}, 32'd1);
  endtask

  task automatic do_load(input logic [DW-1:0] d, input string tag);
    logic [AW-1:0] a;
    a = tgt();
    sw_data_i = d;
    press(6'b000001);
    chk({tag, "_req"}, {mem_val_o, mem_wen_o, pc_wen_o}, 3'b111);
    chk({tag, "_addr"}, {mem_addr_o, pc_o}, {a, a});
    @(negedge clk_i);
    chk({tag, "_disp"}, {disp_addr_o, disp_data_o}, {a, d});
    ref_mem[a] = d; exp_cur = a; exp_auto = 1'b1;
  endtask

  task automatic do_look(input string tag);
    logic [AW-1:0] a;
    a = tgt();
    press(6'b000010);
    chk({tag, "_req"}, {mem_val_o, mem_wen_o, pc_wen_o, mem_addr_o}, {3'b101, a});
    @(negedge clk_i);
    @(negedge clk_i);
    chk({tag, "_disp"}, {disp_addr_o, disp_data_o}, {a, ref_mem[a]});
    exp_cur = a; exp_auto = 1'b1;
  endtask

  initial begin
    int base, n, er;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst_i = 1'b1;
    {btn_stop_i, btn_enter_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i} = '0;
    sw_addr_i = '0; sw_data_i = '0; sw_step_i = '0; auto_inc_i = 1'b0;
    brk_en_i = '0; brk_addr_i = '0; mem_rdy_i = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_cur = '0; exp_auto = 1'b0; exp_pc = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_lamps", {led_ready_o, led_inwait_o, led_halt_o, led_brk_o}, 4'b1000);
    chk("rst_en", {btn_load_o, btn_look_o, btn_step_o, btn_run_o, btn_enter_o, btn_stop_o}, 6'b111110);
    chk("rst_regs", {mem_val_o, pc_wen_o, core_run_o, disp_addr_o, disp_data_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // auto-increment loads from 0x10
    auto_inc_i = 1'b1; sw_addr_i = 8'h10;
    do_load(16'h1111, "ld0");
    do_load(16'h2222, "ld1");
    do_load(16'h3333, "ld2");
    chk("ld_final_addr", disp_addr_o, 8'h12);

    // address wrap
    auto_inc_i = 1'b0; sw_addr_i = 8'hFF;
    do_load(16'($urandom), "ldff");
    auto_inc_i = 1'b1;
    do_load(16'($urandom), "ldwrap");
    chk("wrap_addr", disp_addr_o, 8'h00);
    do_look("lkinc");

    // direct look back at a loaded word
    auto_inc_i = 1'b0; sw_addr_i = 8'h11;
    do_look("lk11");
    chk("lk11_word", disp_data_o, 16'h2222);

    // step 3 from 0x10
    sw_addr_i = 8'h10;
    do_look("lk10");
    sw_step_i = 8'd3; base = ret_cnt;
    press(6'b000100); exp_auto = 1'b0;
    chk("step_stop_en", btn_stop_o, 1'b0);
    wait_lamp(0, "step3_ready");
    chk("step3_cnt", ret_cnt - base, 3);
    chk("step3_runlow", run_at_ret, 1'b0);
    chk("step3_disp", {disp_addr_o, disp_data_o}, {8'h13, ref_mem[8'h13]});
    exp_pc = 8'h13;

    // random step counts, 0 treated as 1
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 0 : int'($urandom_range(5, 1));
      er = (n == 0) ? 1 : n;
      sw_step_i = 8'(n); base = ret_cnt;
      press(6'b000100);
      wait_lamp(0, "stepn_ready");
      chk("stepn_cnt", ret_cnt - base, er);
      exp_pc = exp_pc + 8'(er);
      chk("stepn_disp", {disp_addr_o, disp_data_o}, {exp_pc, ref_mem[exp_pc]});
    end

    // run and step together: run wins, then stop button
    base = ret_cnt;
    press(6'b001100);
    chk("runstep_is_run", {btn_stop_o, core_run_o}, 2'b11);
    repeat ($urandom_range(15, 5)) @(negedge clk_i);
    press(6'b100000);
    wait_lamp(0, "stopbtn_ready");
    exp_pc = exp_pc + 8'(ret_cnt - base);
    chk("stopbtn_disp", disp_addr_o, exp_pc);

    // breakpoint at 0x15 from 0x10
    sw_addr_i = 8'h10; do_look("lkbrk");
    brk_addr_i = $urandom; brk_addr_i[2*AW +: AW] = 8'h15; brk_en_i = 4'b0100;
    base = ret_cnt;
    press(6'b001000);
    wait_lamp(0, "brk_ready");
    chk("brk_led", led_brk_o, 1'b1);
    chk("brk_cnt", ret_cnt - base, 5);
    chk("brk_disp", {disp_addr_o, disp_data_o}, {8'h15, ref_mem[8'h15]});
    base = ret_cnt;
    press(6'b001000);
    chk("brk_clr", led_brk_o, 1'b0);
    repeat ($urandom_range(20, 10)) @(negedge clk_i);
    press(6'b100000);
    wait_lamp(0, "resume_ready");
    chk("resume_moved", (ret_cnt - base) > 0, 1'b1);
    chk("resume_disp", disp_addr_o, 8'h15 + 8'(ret_cnt - base));
    chk("resume_nobrk", led_brk_o, 1'b0);

    // halt coinciding with breakpoint
    halt_addr = 8'h30; brk_addr_i[0 +: AW] = 8'h31; brk_en_i = 4'b0001;
    sw_addr_i = 8'h2C; do_look("lkhalt");
    base = ret_cnt;
    press(6'b001000);
    wait_lamp(1, "halt_lamp");
    chk("halt_nobrk", led_brk_o, 1'b0);
    chk("halt_cnt", ret_cnt - base, 5);
    chk("halt_disp", disp_addr_o, 8'h31);
    chk("halt_en", {btn_load_o, btn_look_o, btn_step_o, btn_run_o, core_run_o}, 5'b11000);
    press(6'b001000);
    chk("halt_run_ign", {led_halt_o, core_run_o}, 2'b10);

    // look in HALT with mem_rdy_i low for 5 cycles and a second press ignored
    halt_addr = 8'hF0; brk_en_i = '0;
    mem_rdy_i = 1'b0; a = 8'($urandom); sw_addr_i = a;
    press(6'b000010);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {mem_val_o, mem_wen_o, mem_addr_o}, {2'b10, a});
      btn_look_i = (i == 1);
      if (i == 1) sw_addr_i = ~a;
      @(negedge clk_i);
    end
    btn_look_i = 1'b0; mem_rdy_i = 1'b1;
    #1;
    chk("stall_accept", {pc_wen_o, pc_o}, {1'b1, a});
    @(negedge clk_i);
    @(negedge clk_i);
    chk("stall_disp", {disp_addr_o, disp_data_o}, {a, ref_mem[a]});
    chk("halt_to_ready", {led_ready_o, led_halt_o, btn_run_o}, 3'b101);
    @(negedge clk_i);
    chk("second_look_ign", mem_val_o, 1'b0);
    exp_cur = a; exp_auto = 1'b1;

    // INWAIT
    inwait_arm = 1'b1; sw_addr_i = 8'h40; auto_inc_i = 1'b0;
    do_look("lkin");
    base = ret_cnt;
    press(6'b001000);
    wait_lamp(2, "inwait_lamp");
    chk("inwait_cnt", ret_cnt - base, 2);
    chk("inwait_disp", {disp_addr_o, disp_data_o}, {8'h42, ref_mem[8'h42]});
    chk("inwait_en", {btn_load_o, btn_look_o, btn_enter_o, btn_run_o, btn_step_o}, 5'b11100);
    inwait_arm = 1'b0;
    press(6'b010000);
    chk("enter_ready", {led_ready_o, led_inwait_o}, 2'b10);

    // load and look together: load wins
    sw_addr_i = 8'h50; d = 16'($urandom); sw_data_i = d;
    press(6'b000011);
    chk("ldlk_wen", {mem_val_o, mem_wen_o, mem_addr_o}, {2'b11, 8'h50});
    @(negedge clk_i);
    chk("ldlk_disp", disp_data_o, d);
    ref_mem[8'h50] = d; exp_cur = 8'h50; exp_auto = 1'b1;
    do_look("lk50");

    // reset in DRAIN
    lat_fixed = 6;
    press(6'b001000);
    repeat (2) @(negedge clk_i);
    press(6'b100000);
    chk("drain_state", {core_run_o, led_ready_o, btn_stop_o}, 3'b000);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ready", {led_ready_o, btn_run_o, btn_load_o, led_brk_o}, 4'b1110);
    chk("midrst_regs", {mem_val_o, disp_addr_o, disp_data_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
